// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV64I load/store unit in front of a 64-bit doubleword data memory
// Optional LSU_PERF_CNT_EN adds load/store/error response counters.
module load_store_unit #(
  parameter int MEM_BYTES = 4096
`ifdef LSU_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_memread,
  output logic        dmem_memwrite,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wd,
  input  logic [63:0] dmem_rd
`ifdef LSU_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_loads
  , output logic [CNT_W-1:0] perf_stores
  , output logic [CNT_W-1:0] perf_errs
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [3:0]  req_size;
  logic [64:0] req_end;
  logic        req_misaligned, req_range, req_illegal, req_bad;
  logic [2:0]  off;
  logic [63:0] shifted, load_ext, bit_mask, merged;
  logic [7:0]  byte_mask;

  // Request checks; the 65-bit end address keeps huge addresses from wrapping into range.
  always_comb begin
    req_size = 4'd1 << req_funct3[1:0];
    req_end  = {1'b0, req_addr} + {61'd0, req_size};
    case (req_funct3[1:0])
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
    req_range   = req_end > 65'(MEM_BYTES);
    req_illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    req_bad     = req_misaligned || req_range || req_illegal;
  end

  always_comb begin
    off     = addr_q[2:0];
    shifted = dmem_rd >> {off, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = shifted;
    endcase
    case (funct3_q[1:0])
      2'b00:   byte_mask = 8'h01 << off;
      2'b01:   byte_mask = 8'h03 << off;
      2'b10:   byte_mask = 8'h0F << off;
      default: byte_mask = 8'hFF;
    endcase
    bit_mask = 64'd0;
    for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    // Shifting wdata up to the byte offset lines its low size bytes with the mask.
    merged = (dmem_rd & ~bit_mask) | ((wdata_q << {off, 3'b000}) & bit_mask);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d     = req_we;
        funct3_d = req_funct3;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        rdata_d  = 64'd0;
        err_d    = req_bad;
        if (req_bad)                                state_d = RESP;
        else if (req_we && req_funct3[1:0] == 2'b11) state_d = WR;
        else                                        state_d = RD;
      end
      RD: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      default: if (resp_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign dmem_memread  = (state_q == RD);
  assign dmem_memwrite = (state_q == WR);
  assign dmem_addr     = (dmem_memread || dmem_memwrite) ? {addr_q[63:3], 3'b000} : 64'd0;
  assign dmem_wd       = dmem_memwrite ? wdata_q : 64'd0;

`ifdef LSU_PERF_CNT_EN
  logic [CNT_W-1:0] loads_q, stores_q, errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (resp_valid && resp_ready) begin
      if (err_q)     errs_q   <= errs_q + 1'b1;
      else if (we_q) stores_q <= stores_q + 1'b1;
      else           loads_q  <= loads_q + 1'b1;
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_errs   = errs_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit with a doubleword memory model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        dmem_memread, dmem_memwrite;
  logic [63:0] dmem_addr, dmem_wd, dmem_rd;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_memread(dmem_memread), .dmem_memwrite(dmem_memwrite),
    .dmem_addr(dmem_addr), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd)
`ifdef LSU_PERF_CNT_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs)
`endif
  );

  // 4 KiB doubleword memory: combinational read, posedge write.
  logic [63:0] mem [512];
  assign dmem_rd = mem[dmem_addr[11:3]];
  always @(posedge clk) if (dmem_memwrite) mem[dmem_addr[11:3]] <= dmem_wd;

  int rd_total = 0, wr_total = 0, both_total = 0;
  always @(negedge clk) begin
    if (dmem_memread) rd_total++;
    if (dmem_memwrite) wr_total++;
    if (dmem_memread && dmem_memwrite) both_total++;
  end

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=0x%h expected=0x%h", tag, what, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_rd, input int exp_wr, input int hold);
    exp_t e;
    int   lat, rd0, wr0, guard;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check(tag, "req_ready", 64'(req_ready), 64'd1);
    rd0 = rd_total;
    wr0 = wr_total;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    check(tag, "latency", 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    check(tag, "rdata", resp_rdata, e.rdata);
    check(tag, "err", 64'(resp_err), 64'(e.err));
    if (hold > 0) begin
      req_valid = 1'b1; req_funct3 = 3'b011; req_addr = 64'h8;
      repeat (hold) begin
        @(negedge clk);
        check(tag, "hold_valid", 64'(resp_valid), 64'd1);
        check(tag, "hold_rdata", resp_rdata, e.rdata);
        check(tag, "hold_req_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check(tag, "rd_cycles", 64'(rd_total - rd0), 64'(exp_rd));
    check(tag, "wr_cycles", 64'(wr_total - wr0), 64'(exp_wr));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] hw;
    int guard;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", "req_ready", 64'(req_ready), 64'd1);
    check("reset", "resp_valid", 64'(resp_valid), 64'd0);
    check("reset", "resp_err", 64'(resp_err), 64'd0);
    check("reset", "resp_rdata", resp_rdata, 64'd0);
    check("reset", "memread", 64'(dmem_memread), 64'd0);
    check("reset", "memwrite", 64'(dmem_memwrite), 64'd0);
    check("reset", "dmem_addr", dmem_addr, 64'd0);
    check("reset", "dmem_wd", dmem_wd, 64'd0);

    // tag, we, f3, addr, wdata, exp_rdata, exp_err, latency, rd, wr, hold
    run_req("sd_10", 1, 3'b011, 64'h10, 64'h1122334455667788, 64'd0, 0, 2, 0, 1, 0);
    run_req("ld_10", 0, 3'b011, 64'h10, 64'd0, 64'h1122334455667788, 0, 2, 1, 0, 0);
    run_req("sb_13", 1, 3'b000, 64'h13, 64'hFFFFFFFFFFFFFFAA, 64'd0, 0, 3, 1, 1, 0);
    check("sb_13", "mem_word", mem[2], 64'h11223344AA667788);
    run_req("ld_10b", 0, 3'b011, 64'h10, 64'd0, 64'h11223344AA667788, 0, 2, 1, 0, 0);

    run_req("sd_20", 1, 3'b011, 64'h20, 64'h80000000FFFF8001, 64'd0, 0, 2, 0, 1, 0);
    run_req("lw_24", 0, 3'b010, 64'h24, 64'd0, 64'hFFFFFFFF80000000, 0, 2, 1, 0, 0);
    run_req("lwu_24", 0, 3'b110, 64'h24, 64'd0, 64'h0000000080000000, 0, 2, 1, 0, 0);
    run_req("lh_20", 0, 3'b001, 64'h20, 64'd0, 64'hFFFFFFFFFFFF8001, 0, 2, 1, 0, 0);
    run_req("lbu_20", 0, 3'b100, 64'h20, 64'd0, 64'h0000000000000001, 0, 2, 1, 0, 0);
    run_req("lb_27", 0, 3'b000, 64'h27, 64'd0, 64'hFFFFFFFFFFFFFF80, 0, 2, 1, 0, 0);
    run_req("lhu_22", 0, 3'b101, 64'h22, 64'd0, 64'h000000000000FFFF, 0, 2, 1, 0, 0);
    run_req("sh_26", 1, 3'b001, 64'h26, 64'h0000000000001234, 64'd0, 0, 3, 1, 1, 0);
    check("sh_26", "mem_word", mem[4], 64'h12340000FFFF8001);

    run_req("lh_21", 0, 3'b001, 64'h21, 64'd0, 64'd0, 1, 1, 0, 0, 0);
    run_req("sw_22", 1, 3'b010, 64'h22, 64'hDEAD, 64'd0, 1, 1, 0, 0, 0);
    run_req("ld_1000", 0, 3'b011, 64'h1000, 64'd0, 64'd0, 1, 1, 0, 0, 0);
    run_req("f3_111", 0, 3'b111, 64'h0, 64'd0, 64'd0, 1, 1, 0, 0, 0);
    run_req("sbu_ill", 1, 3'b100, 64'h10, 64'h55, 64'd0, 1, 1, 0, 0, 0);
    check("sbu_ill", "mem_word", mem[2], 64'h11223344AA667788);

    run_req("sd_ff8", 1, 3'b011, 64'hFF8, 64'h0123456789ABCDEF, 64'd0, 0, 2, 0, 1, 0);
    run_req("lw_ffc", 0, 3'b010, 64'hFFC, 64'd0, 64'h0000000001234567, 0, 2, 1, 0, 0);
    run_req("sw_ffc", 1, 3'b010, 64'hFFC, 64'h00000000DEADBEEF, 64'd0, 0, 3, 1, 1, 0);
    run_req("lwu_ffc", 0, 3'b110, 64'hFFC, 64'd0, 64'h00000000DEADBEEF, 0, 2, 1, 0, 0);
    run_req("lh_fff", 0, 3'b001, 64'hFFF, 64'd0, 64'd0, 1, 1, 0, 0, 0);
    run_req("lb_1000", 0, 3'b000, 64'h1000, 64'd0, 64'd0, 1, 1, 0, 0, 0);

    run_req("ld_hold", 0, 3'b011, 64'h10, 64'd0, 64'h11223344AA667788, 0, 2, 1, 0, 5);

    // Reset while an SH sits in WR; the write may or may not land.
    run_req("sd_30", 1, 3'b011, 64'h30, 64'hCAFEBABE12345678, 64'd0, 0, 2, 0, 1, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 64'h32; req_wdata = 64'hBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    guard = 0;
    @(negedge clk);
    while (!dmem_memwrite && guard < 10) begin @(negedge clk); guard++; end
    check("rst_wr", "reached_wr", 64'(dmem_memwrite), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr", "req_ready", 64'(req_ready), 64'd1);
    check("rst_wr", "resp_valid", 64'(resp_valid), 64'd0);
    check("rst_wr", "memwrite", 64'(dmem_memwrite), 64'd0);
    check("rst_wr", "memread", 64'(dmem_memread), 64'd0);
`ifdef LSU_PERF_CNT_EN
    check("rst_wr", "perf_loads", 64'(perf_loads), 64'd0);
    check("rst_wr", "perf_stores", 64'(perf_stores), 64'd0);
    check("rst_wr", "perf_errs", 64'(perf_errs), 64'd0);
`endif
    hw = mem[6][31:16];
    check("rst_wr", "mem_half_legal", 64'(hw == 16'h1234 || hw == 16'hBEEF), 64'd1);
    check("rst_wr", "mem_low_kept", 64'(mem[6][15:0]), 64'h5678);
    run_req("lh_32", 0, 3'b001, 64'h32, 64'd0, {{48{hw[15]}}, hw}, 0, 2, 1, 0, 0);
`ifdef LSU_PERF_CNT_EN
    check("perf", "loads_after", 64'(perf_loads), 64'd1);
`endif

    check("global", "rd_wr_overlap", 64'(both_total), 64'd0);
    check("global", "sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
